// File: rtl/div_iter_pkg.sv
// Shared op encodings, FSM state type and width defaults for the iterative divider.
package div_iter_pkg;
  localparam int DIV_XLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_t;

  // Bit 0 clear means a signed op; bit 1 set selects the remainder.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction
endpackage

// File: rtl/div_iter_if.sv
// EX-stage to divider handshake: request, operands, busy/done and result.
interface div_iter_if #(
  parameter int XLEN = div_iter_pkg::DIV_XLEN
);
  logic            div_start_i;
  logic            div_cancel_i;
  logic [1:0]      div_op_i;
  logic [XLEN-1:0] div_op1_i;
  logic [XLEN-1:0] div_op2_i;
  logic            div_busy_o;
  logic            div_done_o;
  logic [XLEN-1:0] div_res_o;

  modport master (
    output div_start_i, div_cancel_i, div_op_i, div_op1_i, div_op2_i,
    input  div_busy_o, div_done_o, div_res_o
  );

  modport slave (
    input  div_start_i, div_cancel_i, div_op_i, div_op1_i, div_op2_i,
    output div_busy_o, div_done_o, div_res_o
  );
endinterface

// File: rtl/div_step.sv
// One restoring division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] dvsr_i,
  input  logic            msb_i,
  output logic [XLEN:0]   rem_o,
  output logic            q_o
);
  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  assign shifted = {rem_i, msb_i};
  assign diff    = shifted - {2'b00, dvsr_i};
  assign q_o     = ~diff[XLEN+1];
  assign rem_o   = q_o ? diff[XLEN:0] : shifted[XLEN:0];
endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, BPC quotient bits per cycle.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int XLEN = DIV_XLEN,
  parameter int BPC  = 1
) (
  input logic       clk,
  input logic       rst_n,
  div_iter_if.slave bus
);
  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t      state_q;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] dvd_q, dvs_q, res_q;
  logic [CW-1:0]   cnt_q;
  logic            neg_q_q, neg_r_q, sel_rem_q, busy_q, done_q;

  // Operand decode at start
  logic            sgn, s1, s2, div0, ovf;
  logic [XLEN-1:0] abs1, abs2, spec_res;

  assign sgn      = op_is_signed(bus.div_op_i);
  assign s1       = sgn & bus.div_op1_i[XLEN-1];
  assign s2       = sgn & bus.div_op2_i[XLEN-1];
  assign abs1     = s1 ? -bus.div_op1_i : bus.div_op1_i;
  assign abs2     = s2 ? -bus.div_op2_i : bus.div_op2_i;
  assign div0     = (bus.div_op2_i == '0);
  assign ovf      = sgn && (bus.div_op1_i == MIN_NEG) && (bus.div_op2_i == '1);
  // Both special cases share q/r shapes: q is ones or op1, r is op1 or zero.
  assign spec_res = op_is_rem(bus.div_op_i) ? (div0 ? bus.div_op1_i : '0)
                                            : (div0 ? '1 : bus.div_op1_i);

  // BPC chained steps; quotient bits fill the vacated dividend LSBs
  logic [BPC:0][XLEN:0] rem_ch;
  logic [BPC-1:0]       q_bits;
  logic [XLEN-1:0]      dvd_nxt;

  assign rem_ch[0] = rem_q;

  for (genvar j = 0; j < BPC; j++) begin : g_step
    div_step #(.XLEN(XLEN)) u_step (
      .rem_i  (rem_ch[j]),
      .dvsr_i (dvs_q),
      .msb_i  (dvd_q[XLEN-1-j]),
      .rem_o  (rem_ch[j+1]),
      .q_o    (q_bits[BPC-1-j])
    );
  end

  assign dvd_nxt = {dvd_q[XLEN-BPC-1:0], q_bits};

  logic [XLEN-1:0] q_fix, r_fix;
  assign q_fix = neg_q_q ? -dvd_q : dvd_q;
  assign r_fix = neg_r_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      sel_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.div_cancel_i) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: if (bus.div_start_i) begin
            busy_q    <= 1'b1;
            sel_rem_q <= op_is_rem(bus.div_op_i);
            neg_q_q   <= s1 ^ s2;
            neg_r_q   <= s1;
            dvd_q     <= abs1;
            dvs_q     <= abs2;
            rem_q     <= '0;
            cnt_q     <= CW'(N);
            if (div0 || ovf) begin
              res_q   <= spec_res;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
          S_CALC: begin
            rem_q <= rem_ch[BPC];
            dvd_q <= dvd_nxt;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= S_FIX;
          end
          S_FIX: begin
            res_q   <= sel_rem_q ? r_fix : q_fix;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.div_busy_o = busy_q;
  assign bus.div_done_o = done_q;
  assign bus.div_res_o  = res_q;
endmodule

// File: tb/tb_div_iter.sv
// Bench for div_iter: BPC=1 and BPC=4 instances driven in lockstep against an arithmetic model.
module tb_div_iter;
  import div_iter_pkg::*;

  localparam int XLEN = 32;
  localparam int L1   = XLEN / 1 + 2;
  localparam int L4   = XLEN / 4 + 2;
  localparam logic [XLEN-1:0] MIN_NEG = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            start = 1'b0, cancel = 1'b0;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] a = '0, b = '0;

  div_iter_if #(.XLEN(XLEN)) if1 ();
  div_iter_if #(.XLEN(XLEN)) if4 ();

  assign if1.div_start_i = start;  assign if4.div_start_i = start;
  assign if1.div_cancel_i = cancel; assign if4.div_cancel_i = cancel;
  assign if1.div_op_i = op;         assign if4.div_op_i = op;
  assign if1.div_op1_i = a;         assign if4.div_op1_i = a;
  assign if1.div_op2_i = b;         assign if4.div_op2_i = b;

  div_iter #(.XLEN(XLEN), .BPC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  div_iter #(.XLEN(XLEN), .BPC(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [1:0] o, input logic [XLEN-1:0] x, y);
    return (y == '0) || (!o[0] && x == MIN_NEG && y == '1);
  endfunction

  // ISA-level reference: plain signed/unsigned division with the two special cases
  function automatic logic [XLEN-1:0] model(input logic [1:0] o, input logic [XLEN-1:0] x, y);
    logic signed [XLEN-1:0] sx, sy;
    logic [XLEN-1:0] q, r;
    sx = x; sy = y;
    if (y == '0) begin
      q = '1; r = x;
    end else if (is_special(o, x, y)) begin
      q = x; r = '0;
    end else if (!o[0]) begin
      q = sx / sy; r = sx % sy;
    end else begin
      q = x / y; r = x % y;
    end
    return o[1] ? r : q;
  endfunction

  task automatic run(input logic [1:0] o, input logic [XLEN-1:0] x, y, exp, input string nm);
    logic sp;
    int lat1, lat4, d1, d4, n1, n4, bz1, bz4;
    logic [XLEN-1:0] r1, r4;
    sp = is_special(o, x, y);
    lat1 = sp ? 1 : L1;
    lat4 = sp ? 1 : L4;
    d1 = -1; d4 = -1; n1 = 0; n4 = 0; bz1 = 0; bz4 = 0; r1 = '0; r4 = '0;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    for (int c = 1; c <= L1 + 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      end
      if (!sp && c == 5) start = 1'b1;
      if (!sp && c == 6) start = 1'b0;
      if (if1.div_done_o) begin n1++; if (d1 < 0) begin d1 = c; r1 = if1.div_res_o; end end
      if (if4.div_done_o) begin n4++; if (d4 < 0) begin d4 = c; r4 = if4.div_res_o; end end
      if (if1.div_busy_o) bz1 = c;
      if (if4.div_busy_o) bz4 = c;
    end
    chk({nm, " res bpc1"}, r1, exp);
    chk({nm, " lat bpc1"}, d1, lat1);
    chk({nm, " ndone bpc1"}, n1, 1);
    chk({nm, " busy_end bpc1"}, bz1, lat1);
    chk({nm, " res bpc4"}, r4, exp);
    chk({nm, " lat bpc4"}, d4, lat4);
    chk({nm, " ndone bpc4"}, n4, 1);
    chk({nm, " busy_end bpc4"}, bz4, lat4);
  endtask

  typedef struct {
    logic [1:0]      o;
    logic [XLEN-1:0] x, y, exp;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int n1, n4, bh;
    logic [XLEN-1:0] old, x, y, e;
    logic [1:0] o;

    tbl[0]  = '{DIV_OP_DIV,  32'd100,        32'd7,          32'd14};
    tbl[1]  = '{DIV_OP_REM,  32'd100,        32'd7,          32'd2};
    tbl[2]  = '{DIV_OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF};
    tbl[3]  = '{DIV_OP_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    tbl[4]  = '{DIV_OP_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    tbl[5]  = '{DIV_OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1};
    tbl[6]  = '{DIV_OP_REMU, 32'hFFFF_FFF9,  32'd2,          32'd1};
    tbl[7]  = '{DIV_OP_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF};
    tbl[8]  = '{DIV_OP_REM,  32'd5,          32'd0,          32'd5};
    tbl[9]  = '{DIV_OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF};
    tbl[10] = '{DIV_OP_REMU, 32'd5,          32'd0,          32'd5};
    tbl[11] = '{DIV_OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    tbl[12] = '{DIV_OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    tbl[13] = '{DIV_OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    tbl[14] = '{DIV_OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2};

    #12;
    chk("reset busy bpc1", {31'd0, if1.div_busy_o}, 32'd0);
    chk("reset done bpc1", {31'd0, if1.div_done_o}, 32'd0);
    chk("reset res bpc1", if1.div_res_o, 32'd0);
    chk("reset busy bpc4", {31'd0, if4.div_busy_o}, 32'd0);
    chk("reset done bpc4", {31'd0, if4.div_done_o}, 32'd0);
    chk("reset res bpc4", if4.div_res_o, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++)
      run(tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].exp, $sformatf("vec%0d", i));

    // Cancel mid-operation: BPC=1 is in CALC, BPC=4 is in FIX when it lands
    old = tbl[14].exp;
    n1 = 0; n4 = 0;
    @(posedge clk); #1;
    start = 1'b1; op = DIV_OP_DIV; a = 32'd1000; b = 32'd3;
    for (int c = 1; c <= L1 + 8; c++) begin
      @(posedge clk); #1;
      if (c == 1) start = 1'b0;
      if (c == 9) cancel = 1'b1;
      if (c == 10) begin
        cancel = 1'b0;
        chk("cancel busy bpc1", {31'd0, if1.div_busy_o}, 32'd0);
        chk("cancel busy bpc4", {31'd0, if4.div_busy_o}, 32'd0);
      end
      if (if1.div_done_o) n1++;
      if (if4.div_done_o) n4++;
    end
    chk("cancel ndone bpc1", n1, 0);
    chk("cancel ndone bpc4", n4, 0);
    chk("cancel res bpc1", if1.div_res_o, old);
    chk("cancel res bpc4", if4.div_res_o, old);

    run(DIV_OP_DIV, 32'd20, 32'd3, 32'd6, "div20_3");

    // Start and cancel together: nothing may start
    n1 = 0; n4 = 0; bh = 0;
    @(posedge clk); #1;
    start = 1'b1; cancel = 1'b1; op = DIV_OP_DIV; a = 32'd9; b = 32'd0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin start = 1'b0; cancel = 1'b0; end
      if (if1.div_done_o) n1++;
      if (if4.div_done_o) n4++;
      if (if1.div_busy_o || if4.div_busy_o) bh++;
    end
    chk("startcancel ndone bpc1", n1, 0);
    chk("startcancel ndone bpc4", n4, 0);
    chk("startcancel busy", bh, 0);
    chk("startcancel res bpc1", if1.div_res_o, 32'd6);

    // Asynchronous reset in the middle of an operation
    @(posedge clk); #1;
    start = 1'b1; op = DIV_OP_DIVU; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset busy bpc1", {31'd0, if1.div_busy_o}, 32'd0);
    chk("midreset res bpc1", if1.div_res_o, 32'd0);
    chk("midreset busy bpc4", {31'd0, if4.div_busy_o}, 32'd0);
    chk("midreset res bpc4", if4.div_res_o, 32'd0);
    #3 rst_n = 1'b1;

    for (int i = 0; i < 1000; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 7);
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (sel == 0) y = '0;
      else if (sel == 1) y = 32'($urandom_range(1, 15));
      else if (sel == 2) begin x = MIN_NEG; y = '1; end
      else if (sel == 3) x = 32'($urandom_range(0, 255));
      e = model(o, x, y);
      run(o, x, y, e, $sformatf("rnd%0d op%0d %h/%h", i, o, x, y));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
